full_adder_8_bit: RTL and testbench
===================================

// Module: full_adder_8_bit
// PURPOSE
//  8-bit unsigned ripple-carry adder, s = a + b, carry-out on cout.
//  Datapath: eight 1-bit full-adder cells (sum = x^y^c, carry = x&y | c&(x^y))
//    chained LSB to MSB; bit-0 carry-in tied to 0.
//  Results registered once; arithmetic leaf of the logic-circuit datapath.
// PARAMETERS
//  none (width fixed at 8; no WIDTH parameter)
// PORTS
//  clk        in   1  system clock; all state updates on rising edge
//  rst_n      in   1  reset, asynchronous, active-low
//  a          in   8  addend A, unsigned
//  b          in   8  addend B, unsigned
//  in_valid   in   1  a/b valid this cycle; result captured when high
//  s          out  8  registered sum bits [7:0]
//  cout       out  1  registered carry out of bit 7
//  out_valid  out  1  high one cycle after an accepted in_valid
//  ovf        out  1  signed overflow; present only with FULL_ADDER_8_BIT_OVF_EN
// BEHAVIOUR
//  Interface: one clock; reset asynchronous, active-low.
//  - Reset (rst_n=0, async, no clk needed): s=8'h00, cout=0, out_valid=0,
//    ovf=0. Held while rst_n low. Release takes effect at the next clk edge.
//  - Arithmetic: {cout,s} = {1'b0,a} + {1'b0,b}, exact 9-bit result,
//    mod-256 wrap on s. Combinational ripple through 8 cells, 8 carry hops.
//  - Latency 1: rising clk with in_valid=1 captures {cout,s} for the current
//    a/b; out_valid=1 the same edge.
//  - in_valid=0 at an edge: s/cout hold their last value; out_valid=0.
//  - No backpressure: back-to-back in_valid gives one result per cycle.
//  - Reset asserted mid-stream clears all outputs immediately. The pending
//    result is discarded.
//  - Boundaries:
//      0x00+0x00 -> 0x00, cout=0
//      0xFF+0xFF -> 0xFE, cout=1
//      0xFF+0x01 -> 0x00, cout=1 (full carry ripple)
//  - No X propagation from the carry chain. Every cell is fully defined.
// CONFIGURATION
//  FULL_ADDER_8_BIT_OVF_EN defined:
//    - ovf port exists.
//    - ovf registered alongside s: ovf = carry_into_bit7 ^ cout.
//    - Reset 0; holds when in_valid=0.
//  Not defined: no ovf port, no overflow logic. All else identical.
// TESTING
//  1. rst_n=0 mid-operation, async -> s=0x00, cout=0, out_valid=0 before any
//     clk edge.
//  2. a=0x1E, b=0x01, in_valid=1, one edge -> s=0x1F, cout=0, out_valid=1.
//  3. a=0x23, b=0x04 on the next cycle -> s=0x27, cout=0; then in_valid=0
//     -> s holds 0x27, out_valid=0.
//  4. a=0xFF, b=0x01 -> s=0x00, cout=1. Then a=0xFF, b=0xFF -> s=0xFE, cout=1.
//  5. OVF_EN on:
//       a=0x80, b=0x80 -> s=0x00, cout=1, ovf=1
//       a=0x7F, b=0x01 -> s=0x80, cout=0, ovf=1
//       a=0x1E, b=0x01 -> ovf=0
//  6. Random a/b, 1000 back-to-back vectors -> {cout,s} matches a+b
//     one cycle later every cycle.

Source files
------------

// File: rtl/full_adder_8_bit.sv
// full_adder_8_bit: 8-bit unsigned ripple-carry adder with a registered result.
// Eight 1-bit full-adder cells are chained LSB to MSB with carry-in tied low.
// {cout,s} is captured on a rising clk edge whenever in_valid is high, and
// out_valid pulses for exactly that cycle.
// Optional: define FULL_ADDER_8_BIT_OVF_EN to add a registered signed-overflow
// flag on port ovf. The flag is the carry into bit 7 XOR the carry out of bit 7.
module full_adder_8_bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       in_valid,
  output logic [7:0] s,
  output logic       cout,
  output logic       out_valid
`ifdef FULL_ADDER_8_BIT_OVF_EN
  ,
  output logic       ovf
`endif
);

  // carry[i] is the carry into cell i; carry[8] is the carry out of bit 7.
  logic [8:0] carry;
  logic [7:0] sum_comb;

  assign carry[0] = 1'b0;

  // Each cell computes sum = x^y^c and carry = x&y | c&(x^y).
  // All cell inputs are defined, so no X can enter the chain from inside.
  for (genvar i = 0; i < 8; i++) begin : g_cell
    logic prop;
    assign prop         = a[i] ^ b[i];
    assign sum_comb[i]  = prop ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & prop);
  end

`ifdef FULL_ADDER_8_BIT_OVF_EN
  logic ovf_comb;
  assign ovf_comb = carry[7] ^ carry[8];
`endif

  // Result register: capture on an accepted input, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= 8'h00;
      cout <= 1'b0;
    end else if (in_valid) begin
      s    <= sum_comb;
      cout <= carry[8];
    end
  end

  // out_valid marks the cycle after each accepted input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

`ifdef FULL_ADDER_8_BIT_OVF_EN
  // The overflow flag is registered alongside s and follows the same hold rule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= ovf_comb;
    end
  end
`endif

endmodule

// File: tb/tb_full_adder_8_bit.sv
// Directed bench for full_adder_8_bit. It also runs a stream of random
// back-to-back vectors and checks each one against a + b.
// The ovf checks are built in only when FULL_ADDER_8_BIT_OVF_EN is defined.
module tb_full_adder_8_bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       in_valid = 1'b0;
  logic [7:0] s;
  logic       cout;
  logic       out_valid;
`ifdef FULL_ADDER_8_BIT_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int failures = 0;

  full_adder_8_bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .s         (s),
    .cout      (cout),
    .out_valid (out_valid)
`ifdef FULL_ADDER_8_BIT_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge, then sample 1 ns after the next rising edge.
  task automatic step(input logic [7:0] va, input logic [7:0] vb, input logic v);
    @(negedge clk);
    a = va;
    b = vb;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [8:0] exp9;

    // Outputs must be cleared while reset is held, even as clk edges occur.
    #2;
    check("reset_s", {8'h0, s}, 16'h0000);
    check("reset_cout", {15'h0, cout}, 16'h0000);
    check("reset_valid", {15'h0, out_valid}, 16'h0000);
    step(8'h55, 8'h22, 1'b1);
    check("reset_held_s", {8'h0, s}, 16'h0000);
    check("reset_held_valid", {15'h0, out_valid}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    step(8'h1E, 8'h01, 1'b1);
    check("t2_s", {8'h0, s}, 16'h001F);
    check("t2_cout", {15'h0, cout}, 16'h0000);
    check("t2_valid", {15'h0, out_valid}, 16'h0001);

    step(8'h23, 8'h04, 1'b1);
    check("t3_s", {8'h0, s}, 16'h0027);
    check("t3_cout", {15'h0, cout}, 16'h0000);
    check("t3_valid", {15'h0, out_valid}, 16'h0001);
    step(8'hAA, 8'hAA, 1'b0);
    check("hold_s", {8'h0, s}, 16'h0027);
    check("hold_valid", {15'h0, out_valid}, 16'h0000);
    step(8'hFF, 8'hFF, 1'b0);
    check("hold2_s", {8'h0, s}, 16'h0027);
    check("hold2_cout", {15'h0, cout}, 16'h0000);

    step(8'h00, 8'h00, 1'b1);
    check("zero_s", {8'h0, s}, 16'h0000);
    check("zero_cout", {15'h0, cout}, 16'h0000);

    step(8'hFF, 8'h01, 1'b1);
    check("ripple_s", {8'h0, s}, 16'h0000);
    check("ripple_cout", {15'h0, cout}, 16'h0001);
    step(8'hFF, 8'hFF, 1'b1);
    check("max_s", {8'h0, s}, 16'h00FE);
    check("max_cout", {15'h0, cout}, 16'h0001);
    step(8'h80, 8'h7F, 1'b1);
    check("nocarry_s", {8'h0, s}, 16'h00FF);
    check("nocarry_cout", {15'h0, cout}, 16'h0000);

`ifdef FULL_ADDER_8_BIT_OVF_EN
    step(8'h80, 8'h80, 1'b1);
    check("ovf_neg_s", {8'h0, s}, 16'h0000);
    check("ovf_neg_cout", {15'h0, cout}, 16'h0001);
    check("ovf_neg", {15'h0, ovf}, 16'h0001);
    step(8'h00, 8'h00, 1'b0);
    check("ovf_hold", {15'h0, ovf}, 16'h0001);
    step(8'h7F, 8'h01, 1'b1);
    check("ovf_pos_s", {8'h0, s}, 16'h0080);
    check("ovf_pos_cout", {15'h0, cout}, 16'h0000);
    check("ovf_pos", {15'h0, ovf}, 16'h0001);
    step(8'h1E, 8'h01, 1'b1);
    check("ovf_none", {15'h0, ovf}, 16'h0000);
    step(8'hFF, 8'h01, 1'b1);
    check("ovf_carry_only", {15'h0, ovf}, 16'h0000);
`endif

    // Reset asserted between clock edges must clear the outputs immediately.
    step(8'hF0, 8'h0F, 1'b1);
    check("pre_rst_s", {8'h0, s}, 16'h00FF);
    @(negedge clk);
    a = 8'h12;
    b = 8'h34;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_s", {8'h0, s}, 16'h0000);
    check("async_rst_cout", {15'h0, cout}, 16'h0000);
    check("async_rst_valid", {15'h0, out_valid}, 16'h0000);
`ifdef FULL_ADDER_8_BIT_OVF_EN
    check("async_rst_ovf", {15'h0, ovf}, 16'h0000);
`endif
    @(posedge clk);
    #1;
    check("rst_discard_s", {8'h0, s}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back random vectors: each is checked the cycle after it is applied.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      exp9 = {1'b0, ra} + {1'b0, rb};
      step(ra, rb, 1'b1);
      check("rand_sum", {7'h0, cout, s}, {7'h0, exp9});
      check("rand_valid", {15'h0, out_valid}, 16'h0001);
    end

    step(8'h00, 8'h00, 1'b0);
    check("end_valid", {15'h0, out_valid}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
